// File: rtl/usb_rx.sv
// usb_rx -- low-speed USB receive path.
// Recovers bit timing from line transitions, NRZI-decodes J/K samples,
// detects SYNC, removes stuffed bits, assembles bytes LSB first and
// handles EOP and abort conditions.
// Optional feature: define USB_RX_STUFF_CHECK_EN to flag a stuffed bit
// that decodes as 1 (rx_error pulse, packet aborted).

module usb_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] line_state,
  output logic [7:0] rx_data,
  output logic       rx_active,
  output logic       rx_valid,
  output logic       rx_error
);

  localparam int PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [PW-1:0] PH_SAMPLE = PW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [PW-1:0] PH_LAST   = PW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_J   = 2'b01;
  localparam logic [1:0] LS_K   = 2'b10;
  localparam logic [1:0] LS_SE1 = 2'b11;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SYNC  = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_EOP   = 3'd3;
  localparam logic [2:0] ST_ABORT = 3'd4;

  // Bit-timing recovery
  logic [1:0]    ls_q;
  logic [PW-1:0] phase_q, phase_d;
  logic          line_change;
  logic          sample;

  // Receive state machine
  logic [2:0] state_q, state_d;
  logic [1:0] prev_q, prev_d;        // level of the previous J/K sample
  logic [2:0] cnt_q, cnt_d;          // SYNC zero run / ABORT J run
  logic [2:0] ones_q, ones_d;        // consecutive decoded 1s in DATA
  logic [2:0] bit_cnt_q, bit_cnt_d;  // bits of the current byte
  logic [7:0] shift_q, shift_d;
  logic       se0_seen_q, se0_seen_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_active_q, rx_active_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_error_q, rx_error_d;
  logic       bit_one;

  assign line_change = (line_state != ls_q);
  assign sample      = (phase_q == PH_SAMPLE);
  // NRZI: an unchanged level decodes as 1, a changed level as 0.
  assign bit_one     = (line_state == prev_q);

  // Phase counter: restart on every line transition, otherwise wrap.
  always_comb begin
    if (line_change || (phase_q == PH_LAST)) phase_d = '0;
    else                                     phase_d = phase_q + 1'b1;
  end

  // Next-state and output decisions, evaluated once per bit at the sample point.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d     = state_q;
    prev_d      = prev_q;
    cnt_d       = cnt_q;
    ones_d      = ones_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    se0_seen_d  = se0_seen_q;
    rx_data_d   = rx_data_q;
    rx_active_d = rx_active_q;
    rx_valid_d  = 1'b0;
    rx_error_d  = 1'b0;

    if (sample) begin
      case (state_q)
        ST_IDLE: begin
          // The first K is itself the first decoded 0 of SYNC.
          if (line_state == LS_K) begin
            state_d = ST_SYNC;
            prev_d  = LS_K;
            cnt_d   = 3'd1;
          end
        end

        ST_SYNC: begin
          case (line_state)
            LS_J, LS_K: begin
              if (!bit_one) begin
                prev_d = line_state;
                if (cnt_q != 3'd7) cnt_d = cnt_q + 3'd1;
              end else if (cnt_q >= 3'd5) begin
                state_d     = ST_DATA;
                prev_d      = line_state;
                rx_active_d = 1'b1;
                ones_d      = 3'd0;
                bit_cnt_d   = 3'd0;
              end else begin
                state_d = ST_IDLE;
                prev_d  = LS_J;
              end
            end
            default: begin
              state_d = ST_IDLE;
              prev_d  = LS_J;
            end
          endcase
        end

        ST_DATA: begin
          case (line_state)
            LS_J, LS_K: begin
              prev_d = line_state;
              if (ones_q == 3'd6) begin
                // Stuffed bit: dropped, restarts the ones run.
                ones_d = 3'd0;
`ifdef USB_RX_STUFF_CHECK_EN
                if (bit_one) begin
                  rx_error_d = 1'b1;
                  state_d    = ST_ABORT;
                  cnt_d      = 3'd0;
                  se0_seen_d = 1'b0;
                end
`else
                // Dropped whatever its value.
`endif
              end else begin
                shift_d   = {bit_one, shift_q[7:1]};
                bit_cnt_d = bit_cnt_q + 3'd1;
                ones_d    = bit_one ? ones_q + 3'd1 : 3'd0;
                if (bit_cnt_q == 3'd7) begin
                  rx_data_d  = shift_d;
                  rx_valid_d = 1'b1;
                end
              end
            end
            LS_SE0: begin
              state_d = ST_EOP;
              // A partial byte at EOP is reported, never delivered.
              if (bit_cnt_q != 3'd0) rx_error_d = 1'b1;
            end
            default: begin
              rx_error_d = 1'b1;
              state_d    = ST_ABORT;
              cnt_d      = 3'd0;
              se0_seen_d = 1'b0;
            end
          endcase
        end

        ST_EOP: begin
          case (line_state)
            LS_J: begin
              state_d     = ST_IDLE;
              prev_d      = LS_J;
              rx_active_d = 1'b0;
            end
            LS_SE0: ;
            default: begin
              rx_error_d = 1'b1;
              state_d    = ST_ABORT;
              cnt_d      = 3'd0;
              se0_seen_d = 1'b0;
            end
          endcase
        end

        ST_ABORT: begin
          // Leave on SE0 followed by J, or on a run of eight J samples.
          case (line_state)
            LS_SE0: begin
              se0_seen_d = 1'b1;
              cnt_d      = 3'd0;
            end
            LS_J: begin
              if (se0_seen_q || (cnt_q == 3'd7)) begin
                state_d     = ST_IDLE;
                prev_d      = LS_J;
                rx_active_d = 1'b0;
                cnt_d       = 3'd0;
                se0_seen_d  = 1'b0;
              end else begin
                cnt_d = cnt_q + 3'd1;
              end
            end
            default: begin
              cnt_d      = 3'd0;
              se0_seen_d = 1'b0;
            end
          endcase
        end

        default: begin
          state_d = ST_IDLE;
          prev_d  = LS_J;
        end
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: the datapath registers (shift, rx_data) are reset along with the
    // control state, so an abandoned packet leaves nothing behind.
    if (!reset) begin
      ls_q        <= LS_J;
      phase_q     <= '0;
      state_q     <= ST_IDLE;
      prev_q      <= LS_J;
      cnt_q       <= 3'd0;
      ones_q      <= 3'd0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      se0_seen_q  <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_active_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_error_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      ls_q        <= line_state;
      phase_q     <= phase_d;
      state_q     <= state_d;
      prev_q      <= prev_d;
      cnt_q       <= cnt_d;
      ones_q      <= ones_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      se0_seen_q  <= se0_seen_d;
      rx_data_q   <= rx_data_d;
      rx_active_q <= rx_active_d;
      rx_valid_q  <= rx_valid_d;
      rx_error_q  <= rx_error_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_active = rx_active_q;
  assign rx_valid  = rx_valid_q;
  assign rx_error  = rx_error_q;

endmodule

// File: doc/usb_rx.md
USB_RX -- requirements
Module: usb_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clk cycles per bit (24 MHz clk, 1.5 Mbit/s low speed).
REQ-002 SHALL have port clk  input  1  system clock (24 MHz); sole clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port line_state  input  2 (d_port_t)  synchronized {D+,D-}: SE0=2'b00, J=2'b01, K=2'b10, SE1=2'b11.
REQ-005 SHALL have port rx_data  output  8  received byte, LSB received first.
REQ-006 SHALL have port rx_active  output  1  high from end of SYNC until end of EOP or abort.
REQ-007 SHALL have port rx_valid  output  1  one-cycle pulse, rx_data valid.
REQ-008 SHALL have port rx_error  output  1  one-cycle pulse, error detected.

Function
REQ-009 SHALL recover bit timing with a 0..CLKS_PER_BIT-1 phase counter, reloaded to 0 on every line_state change and otherwise wrapping.
REQ-010 SHALL sample line_state once per bit, at phase CLKS_PER_BIT/2-1 (7 at default).
REQ-011 SHALL NRZI-decode each J/K sample: same level as previous sample -> 1; changed level -> 0; previous level SHALL be J in IDLE.
REQ-012 SHALL implement states IDLE, SYNC, DATA, EOP, ABORT.
REQ-013 IDLE -> SYNC on first K sample.
REQ-014 SYNC -> DATA on a decoded 1 preceded by >=5 consecutive decoded 0s; rx_active rises the cycle after that sample.
REQ-015 SYNC -> IDLE on SE0 or SE1 sample, or on a 1 preceded by <5 zeros; no outputs asserted.
REQ-016 DATA: after six consecutive decoded 1s the next bit SHALL be discarded (unstuffed); the ones-run counter SHALL reset on any 0 and on the discarded bit.
REQ-017 DATA: non-discarded bits SHALL shift in LSB first; on the 8th bit rx_data SHALL update and rx_valid pulse the following cycle.
REQ-018 DATA -> EOP on SE0 sample; EOP -> IDLE on the next J sample, rx_active falling the same cycle.
REQ-019 At EOP entry with a nonzero partial-byte bit count, rx_error SHALL pulse and no rx_valid SHALL be issued for the partial byte.
REQ-020 SE1 sample in DATA or EOP, or K sample in EOP, SHALL pulse rx_error and enter ABORT.
REQ-021 ABORT -> IDLE after SE0 then J sample, or after 8 consecutive J samples; rx_active falls on that transition.
REQ-022 rx_valid and rx_error SHALL only assert while rx_active is high and SHALL never assert in the same cycle.
REQ-023 rx_data SHALL hold its last value until the next completed byte.
REQ-024 Latency: rx_valid SHALL assert within 2 clk cycles after the sample of the byte's 8th bit.

Reset
REQ-025 reset low SHALL asynchronously force state IDLE, rx_data=8'h00, rx_active=0, rx_valid=0, rx_error=0, counters 0, previous level J.
REQ-026 reset asserted mid-packet SHALL abandon the packet; after release the block SHALL wait in IDLE for the next K; no output pulse SHALL result from the abandoned packet.

Configuration
REQ-027 With macro USB_RX_STUFF_CHECK_EN defined, a discarded stuff bit decoding as 1 SHALL pulse rx_error and enter ABORT.
REQ-028 Without USB_RX_STUFF_CHECK_EN, the stuff bit SHALL be discarded regardless of value and no stuff error SHALL be reported.

Verification
REQ-029 SYNC KJKJKJKK, byte 8'hA5, SE0 x2 bits, J -> rx_active high, one rx_valid with rx_data=8'hA5, rx_active low after J, no rx_error.
REQ-030 SYNC, bytes 8'hFF,8'h01 (stuff 0 inserted after 6 ones) -> rx_valid twice, rx_data 8'hFF then 8'h01, no rx_error.
REQ-031 SYNC, 8'h3C, 5 extra bits, SE0, J -> one rx_valid (8'h3C), then one rx_error pulse at EOP, rx_active falls after J.
REQ-032 SYNC, six 1s then stuff bit as 1 -> rx_error pulse and ABORT with USB_RX_STUFF_CHECK_EN; bit dropped, reception continues without it.
REQ-033 Each bit period jittered +-1 clk over a 3-byte packet 8'h69,8'h00,8'hFF -> all three bytes received correctly.
REQ-034 reset pulsed low during 2nd byte, then a new 8'h5A packet -> outputs zero during reset, no stale pulse, 8'h5A received.
